// File: rtl/monitor_cmd_dispatch_pkg.sv
// Shared definitions for the monitor command dispatcher: command field map,
// FSM state encoding and response packing.
package monitor_pkg;

  localparam int CMD_W  = 40;
  localparam int MSG_W  = 40;
  localparam int GRP_W  = 7;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int CMD_WR_BIT   = 39;
  localparam int CMD_GRP_MSB  = 38;
  localparam int CMD_GRP_LSB  = 32;
  localparam int CMD_ADDR_MSB = 31;
  localparam int CMD_ADDR_LSB = 16;
  localparam int CMD_DATA_MSB = 15;
  localparam int CMD_DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } dispatch_state_t;

  function automatic logic [MSG_W-1:0] pack_resp(input logic [GRP_W-1:0]  grp,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] data);
    return {1'b0, grp, addr, data};
  endfunction

endpackage

// File: rtl/monitor_cmd_dispatch_if.sv
// Command-queue, monitor-bus and read-message signals of the dispatcher.
// master = dispatcher side, slave = FIFOs / register groups side.
interface monitor_cmd_dispatch_if;
  import monitor_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_ready;
  logic              cmd_read_en;
  logic [GRP_W-1:0]  bus_group;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wr_en;
  logic              bus_rd_en;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic [MSG_W-1:0]  read_msg;
  logic              read_msg_ready;
  logic              busy;

  modport master (
    input  cmd, cmd_ready, bus_rdata, bus_ack,
    output cmd_read_en, bus_group, bus_addr, bus_wdata, bus_wr_en, bus_rd_en,
           read_msg, read_msg_ready, busy
  );

  modport slave (
    output cmd, cmd_ready, bus_rdata, bus_ack,
    input  cmd_read_en, bus_group, bus_addr, bus_wdata, bus_wr_en, bus_rd_en,
           read_msg, read_msg_ready, busy
  );

endinterface

// File: rtl/monitor_cmd_dispatch_timer.sv
// monitor_bus_timer: WAIT-state ack watchdog, built only with MON_BUS_TIMEOUT_EN.
// tc is raised in the WAIT cycle that completes TIMEOUT_CYCLES cycles of waiting.
`ifdef MON_BUS_TIMEOUT_EN
module monitor_bus_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (srst || clr)    cnt <= '0;
    else if (en && !tc) cnt <= cnt + 8'd1;
  end

  assign tc = en && (cnt == TC_VAL);

endmodule
`endif

// File: rtl/monitor_cmd_dispatch.sv
// Pops 40-bit monitor commands, runs one bus read/write each, pushes read responses.
// Optional ack watchdog enabled by defining MON_BUS_TIMEOUT_EN.
module monitor_cmd_dispatch
  import monitor_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = 16'hDEAD
) (
  input  logic                   clk,
  input  logic                   srst,
  monitor_cmd_dispatch_if.master mif
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  dispatch_state_t   state;
  logic              op_wr;
  logic              wait_done;
  logic [DATA_W-1:0] resp_data;

`ifdef MON_BUS_TIMEOUT_EN
  logic tmo;

  monitor_bus_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk  (clk),
    .srst (srst),
    .clr  (state == ISSUE),
    .en   (state == WAIT),
    .tc   (tmo)
  );

  assign wait_done = mif.bus_ack | tmo;
`else
  assign wait_done = mif.bus_ack;
`endif

  // An ack on the terminal cycle still carries real data.
  assign resp_data = mif.bus_ack ? mif.bus_rdata : ERR_DATA;

  // Pop is a decode of the registered state, so it lands in the IDLE cycle
  // and the FIFO head is valid during LATCH.
  assign mif.cmd_read_en = !srst && (state == IDLE) && mif.cmd_ready;
  assign mif.busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (srst) begin
      state              <= IDLE;
      op_wr              <= 1'b0;
      mif.bus_group      <= '0;
      mif.bus_addr       <= '0;
      mif.bus_wdata      <= '0;
      mif.bus_wr_en      <= 1'b0;
      mif.bus_rd_en      <= 1'b0;
      mif.read_msg       <= '0;
      mif.read_msg_ready <= 1'b0;
    end else begin
      mif.bus_wr_en      <= 1'b0;
      mif.bus_rd_en      <= 1'b0;
      mif.read_msg_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mif.cmd_ready) state <= LATCH;
        end
        LATCH: begin
          op_wr         <= mif.cmd[CMD_WR_BIT];
          mif.bus_group <= mif.cmd[CMD_GRP_MSB:CMD_GRP_LSB];
          mif.bus_addr  <= mif.cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
          mif.bus_wdata <= mif.cmd[CMD_DATA_MSB:CMD_DATA_LSB];
          // Strobes are registered so they are high exactly during ISSUE.
          mif.bus_wr_en <= mif.cmd[CMD_WR_BIT];
          mif.bus_rd_en <= !mif.cmd[CMD_WR_BIT];
          state         <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (wait_done) begin
            if (op_wr) begin
              state <= IDLE;
            end else begin
              mif.read_msg       <= pack_resp(mif.bus_group, mif.bus_addr, resp_data);
              mif.read_msg_ready <= 1'b1;
              state              <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_cmd_dispatch.sv
// Scoreboard bench for monitor_cmd_dispatch; timeout scenarios run when
// MON_BUS_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=8).
module tb_monitor_cmd_dispatch;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  monitor_cmd_dispatch_if mif();

  monitor_cmd_dispatch #(.TIMEOUT_CYCLES(8), .ERR_DATA(16'hDEAD)) dut (
    .clk  (clk),
    .srst (srst),
    .mif  (mif)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [39:0] cmdq[$];
  logic [15:0] rdq[$];
  logic [39:0] exp_msg_q[$];
  logic [38:0] exp_wr_q[$];
  logic [22:0] exp_rd_q[$];
  int          pop_cyc_q[$];

  int cyc = 0;
  int ack_delay = 1;
  bit inject_ack = 1'b0;
  int n_pop = 0, n_resp = 0, n_rd = 0, n_overlap = 0, n_busy = 0;
  int last_pop_cyc = 0, last_resp_cyc = 0, last_rd_cyc = 0;

  // Command FIFO: head becomes valid the cycle after the pop.
  initial begin : feeder
    bit p;
    mif.cmd = '0;
    mif.cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      p = mif.cmd_read_en;
      @(posedge clk);
      #1;
      if (p && cmdq.size() > 0) mif.cmd = cmdq.pop_front();
      mif.cmd_ready = (cmdq.size() > 0);
    end
  end

  // Bus slave: ack ack_delay cycles after the strobe cycle (0 = never).
  initial begin : bus_model
    int cd;
    bit rd_seen, wr_seen;
    cd = 0;
    mif.bus_ack = 1'b0;
    mif.bus_rdata = '0;
    forever begin
      @(negedge clk);
      rd_seen = mif.bus_rd_en;
      wr_seen = mif.bus_wr_en;
      @(posedge clk);
      #1;
      mif.bus_ack = 1'b0;
      if (rd_seen || wr_seen) begin
        cd = ack_delay;
        if (rd_seen) mif.bus_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'h0000;
      end
      if (inject_ack) begin
        mif.bus_ack = 1'b1;
        inject_ack = 1'b0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) mif.bus_ack = 1'b1;
      end
    end
  end

  // Scoreboard: pop expectations as the DUT produces strobes/responses.
  initial begin : monitor
    logic [39:0] em;
    logic [38:0] ew;
    logic [22:0] er;
    forever begin
      @(negedge clk);
      cyc++;
      if (!srst) begin
        if (mif.busy) n_busy++;
        if (mif.cmd_read_en) begin
          n_pop++;
          last_pop_cyc = cyc;
          pop_cyc_q.push_back(cyc);
          if (mif.busy) n_overlap++;
        end
        if (mif.bus_rd_en) begin
          n_rd++;
          last_rd_cyc = cyc;
          n_chk++;
          if (exp_rd_q.size() == 0) $display("FAIL rd_strobe: unexpected read grp=%h addr=%h", mif.bus_group, mif.bus_addr);
          else begin
            er = exp_rd_q.pop_front();
            if ({mif.bus_group, mif.bus_addr} !== er) $display("FAIL rd_strobe: got %h want %h", {mif.bus_group, mif.bus_addr}, er);
            else n_pass++;
          end
        end
        if (mif.bus_wr_en) begin
          n_chk++;
          if (exp_wr_q.size() == 0) $display("FAIL wr_strobe: unexpected write %h", {mif.bus_group, mif.bus_addr, mif.bus_wdata});
          else begin
            ew = exp_wr_q.pop_front();
            if ({mif.bus_group, mif.bus_addr, mif.bus_wdata} !== ew) $display("FAIL wr_strobe: got %h want %h", {mif.bus_group, mif.bus_addr, mif.bus_wdata}, ew);
            else n_pass++;
          end
        end
        if (mif.read_msg_ready) begin
          n_resp++;
          last_resp_cyc = cyc;
          n_chk++;
          if (exp_msg_q.size() == 0) $display("FAIL read_msg: unexpected push %h", mif.read_msg);
          else begin
            em = exp_msg_q.pop_front();
            if (mif.read_msg !== em) $display("FAIL read_msg: got %h want %h", mif.read_msg, em);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    @(negedge clk);
    while ((cmdq.size() > 0 || exp_msg_q.size() > 0 || exp_wr_q.size() > 0 ||
            exp_rd_q.size() > 0 || mif.busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (i >= budget) $display("FAIL %s_drain: still busy after %0d cycles (limit %0d)", tag, i, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mif.cmd_read_en, mif.bus_wr_en, mif.bus_rd_en, mif.read_msg_ready, mif.busy} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000", {mif.cmd_read_en, mif.bus_wr_en, mif.bus_rd_en, mif.read_msg_ready, mif.busy});
    else n_pass++;
    n_chk++;
    if ({mif.bus_group, mif.bus_addr, mif.bus_wdata, mif.read_msg} !== 79'b0)
      $display("FAIL reset_data: got %h want 0", {mif.bus_group, mif.bus_addr, mif.bus_wdata, mif.read_msg});
    else n_pass++;
    srst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int p0, r0;
    p0 = n_pop; r0 = n_resp;
    ack_delay = 2;
    rdq.push_back(16'hBEEF);
    exp_rd_q.push_back({7'h05, 16'h1234});
    exp_msg_q.push_back(40'h05_1234_BEEF);
    cmdq.push_back(40'h05_1234_0000);
    wait_idle("read", 50);
    n_chk++;
    if (n_pop - p0 != 1 || n_resp - r0 != 1) $display("FAIL read_count: pops=%0d resps=%0d want 1/1", n_pop - p0, n_resp - r0);
    else n_pass++;
    n_chk++;
    if (last_resp_cyc - last_rd_cyc != 3) $display("FAIL read_ack_latency: rd->resp=%0d want 3", last_resp_cyc - last_rd_cyc);
    else n_pass++;
  endtask

  task automatic test_write();
    int p0, r0, b0;
    p0 = n_pop; r0 = n_resp; b0 = n_busy;
    ack_delay = 1;
    exp_wr_q.push_back({7'h03, 16'h0042, 16'hA5A5});
    cmdq.push_back(40'h83_0042_A5A5);
    wait_idle("write", 50);
    n_chk++;
    if (n_pop - p0 != 1 || n_resp - r0 != 0) $display("FAIL write_count: pops=%0d resps=%0d want 1/0", n_pop - p0, n_resp - r0);
    else n_pass++;
    n_chk++;
    if (n_busy - b0 != 3) $display("FAIL write_turnaround: busy cycles=%0d want 3", n_busy - b0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p0, r0;
    p0 = n_pop; r0 = n_resp;
    pop_cyc_q.delete();
    ack_delay = 1;
    rdq.push_back(16'h1111);
    rdq.push_back(16'hFFFF);
    exp_rd_q.push_back({7'h11, 16'h0100});
    exp_wr_q.push_back({7'h22, 16'h0200, 16'h1357});
    exp_rd_q.push_back({7'h7F, 16'hFFFF});
    exp_msg_q.push_back(40'h11_0100_1111);
    exp_msg_q.push_back(40'h7F_FFFF_FFFF);
    cmdq.push_back(40'h11_0100_0000);
    cmdq.push_back(40'hA2_0200_1357);
    cmdq.push_back(40'h7F_FFFF_0000);
    wait_idle("b2b", 100);
    n_chk++;
    if (n_pop - p0 != 3 || n_resp - r0 != 2) $display("FAIL b2b_count: pops=%0d resps=%0d want 3/2", n_pop - p0, n_resp - r0);
    else n_pass++;
    n_chk++;
    if (n_overlap != 0) $display("FAIL b2b_pop_while_busy: count=%0d want 0", n_overlap);
    else n_pass++;
    n_chk++;
    if (pop_cyc_q.size() != 3) $display("FAIL b2b_gaps: pops recorded=%0d want 3", pop_cyc_q.size());
    else if (pop_cyc_q[1] - pop_cyc_q[0] != 5 || pop_cyc_q[2] - pop_cyc_q[1] != 4)
      $display("FAIL b2b_gaps: gaps=%0d,%0d want 5,4", pop_cyc_q[1] - pop_cyc_q[0], pop_cyc_q[2] - pop_cyc_q[1]);
    else n_pass++;
    // Immediate ack: pop in IDLE, push in RESP four cycles later (5 inclusive).
    n_chk++;
    if (last_resp_cyc - last_pop_cyc != 4) $display("FAIL b2b_min_latency: pop->resp=%0d want 4", last_resp_cyc - last_pop_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int r0, rd0, i;
    r0 = n_resp; rd0 = n_rd;
    ack_delay = 0;
    rdq.push_back(16'h7777);
    exp_rd_q.push_back({7'h44, 16'h0444});
    cmdq.push_back(40'h44_0444_0000);
    i = 0;
    while (n_rd == rd0 && i < 50) begin @(negedge clk); i++; end
    n_chk++;
    if (i >= 50) $display("FAIL rstwait_strobe: no read strobe in %0d cycles", i);
    else n_pass++;
    repeat (2) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    inject_ack = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({mif.cmd_read_en, mif.bus_wr_en, mif.bus_rd_en, mif.read_msg_ready, mif.busy} !== 5'b0)
      $display("FAIL rstwait_strobes: got %b want 00000", {mif.cmd_read_en, mif.bus_wr_en, mif.bus_rd_en, mif.read_msg_ready, mif.busy});
    else n_pass++;
    n_chk++;
    if ({mif.bus_group, mif.bus_addr, mif.bus_wdata, mif.read_msg} !== 79'b0)
      $display("FAIL rstwait_data: got %h want 0", {mif.bus_group, mif.bus_addr, mif.bus_wdata, mif.read_msg});
    else n_pass++;
    n_chk++;
    if (n_resp != r0) $display("FAIL rstwait_no_resp: pushes=%0d want 0", n_resp - r0);
    else n_pass++;
    ack_delay = 1;
  endtask

`ifdef MON_BUS_TIMEOUT_EN
  task automatic test_timeout();
    ack_delay = 0;
    rdq.push_back(16'h1234);
    exp_rd_q.push_back({7'h09, 16'h0900});
    exp_msg_q.push_back(40'h09_0900_DEAD);
    cmdq.push_back(40'h09_0900_0000);
    wait_idle("timeout_rd", 60);
    n_chk++;
    if (last_resp_cyc - last_rd_cyc != 9) $display("FAIL timeout_latency: rd->resp=%0d want 9", last_resp_cyc - last_rd_cyc);
    else n_pass++;
    exp_wr_q.push_back({7'h0A, 16'h0A00, 16'h00AA});
    cmdq.push_back(40'h8A_0A00_00AA);
    wait_idle("timeout_wr", 60);
    ack_delay = 1;
  endtask

  task automatic test_timeout_boundary();
    ack_delay = 8;
    rdq.push_back(16'h600D);
    exp_rd_q.push_back({7'h0B, 16'h0B0B});
    exp_msg_q.push_back(40'h0B_0B0B_600D);
    cmdq.push_back(40'h0B_0B0B_0000);
    wait_idle("timeout_edge", 60);
    n_chk++;
    if (last_resp_cyc - last_rd_cyc != 9) $display("FAIL timeout_edge_latency: rd->resp=%0d want 9", last_resp_cyc - last_rd_cyc);
    else n_pass++;
    ack_delay = 1;
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef MON_BUS_TIMEOUT_EN
    test_timeout();
    test_timeout_boundary();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
